// File: rtl/pb2_autoindex_unit_pkg.sv
// rtl/pb2_autoindex_unit_pkg.sv - shared constants, state encoding and window helper for the PB2 autoindex unit
package pb2_autoindex_unit_pkg;

  localparam int unsigned DEF_W       = 16;
  localparam int unsigned DEF_OPW     = 10;
  localparam int unsigned DEF_AI_BASE = 'h080;
  localparam int unsigned DEF_AI_SIZE = 'h080;
  localparam int unsigned DEF_AD_BASE = 'h100;
  localparam int unsigned DEF_AD_SIZE = 'h000;

  // I and R sit directly above the operand field: I = bit OPW+1, R = bit OPW.
  localparam int unsigned I_OFS = 1;
  localparam int unsigned R_OFS = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MOD  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic in_window(input logic [31:0] op,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (size != 32'd0) && (op >= base) && (op < base + size);
  endfunction

endpackage

// File: rtl/pb2_autoindex_unit_ai_decode.sv
// rtl/pb2_autoindex_unit_ai_decode.sv - registered instruction latch and window match (naindex, dec)
module pb2_ai_decode
  import pb2_autoindex_unit_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned OPW     = DEF_OPW,
  parameter int unsigned AI_BASE = DEF_AI_BASE,
  parameter int unsigned AI_SIZE = DEF_AI_SIZE,
  parameter int unsigned AD_BASE = DEF_AD_BASE,
  parameter int unsigned AD_SIZE = DEF_AD_SIZE
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           latch_en,
  input  logic [W-1:0]   ibus,
  output logic           naindex,
  output logic           dec,
  output logic [OPW-1:0] operand
);

  logic           naindex_d, naindex_q;
  logic           dec_d, dec_q;
  logic [OPW-1:0] operand_d, operand_q;
  logic           ir_hit, ai_hit, ad_hit;
  logic           unused_hi;

  assign unused_hi = ^ibus[W-1:OPW+2];
  assign ir_hit    = ibus[OPW+I_OFS] & ibus[OPW+R_OFS];
  assign ai_hit    = in_window(32'(ibus[OPW-1:0]), AI_BASE, AI_SIZE);
  assign ad_hit    = in_window(32'(ibus[OPW-1:0]), AD_BASE, AD_SIZE);

  // Overlapping windows resolve to increment.
  always_comb begin
    naindex_d = naindex_q;
    dec_d     = dec_q;
    operand_d = operand_q;
    if (latch_en) begin
      operand_d = ibus[OPW-1:0];
      naindex_d = !(ir_hit && (ai_hit || ad_hit));
      dec_d     = ir_hit && !ai_hit && ad_hit;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      naindex_q <= 1'b1;
      dec_q     <= 1'b0;
      operand_q <= '0;
    end else begin
      naindex_q <= naindex_d;
      dec_q     <= dec_d;
      operand_q <= operand_d;
    end
  end

  assign naindex = naindex_q;
  assign dec     = dec_q;
  assign operand = operand_q;

endmodule

// File: rtl/pb2_autoindex_unit.sv
// rtl/pb2_autoindex_unit.sv - autoindex/autodecrement decode plus page-zero pointer read-modify-write sequencer
module pb2_autoindex_unit
  import pb2_autoindex_unit_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned OPW     = DEF_OPW,
  parameter int unsigned AI_BASE = DEF_AI_BASE,
  parameter int unsigned AI_SIZE = DEF_AI_SIZE,
  parameter int unsigned AD_BASE = DEF_AD_BASE,
  parameter int unsigned AD_SIZE = DEF_AD_SIZE,
  parameter int unsigned STEP    = 1,
  parameter int unsigned PRE     = 0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] ibus,
  input  logic         nwir,
  input  logic         start,
  output logic         naindex,
  output logic         dec,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic [W-1:0] ptr,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  state_t         state_d, state_q;
  logic [W-1:0]   old_d, old_q;
  logic [W-1:0]   ptr_d, ptr_q;
  logic [W-1:0]   wdata_d, wdata_q;
  logic           overrun_d, overrun_q;
  logic [W-1:0]   new_val;
  logic [OPW-1:0] operand;
  logic           latch_en;

  // The instruction latch is frozen while a pointer update is in flight.
  assign latch_en = !nwir && (state_q == ST_IDLE);

  pb2_ai_decode #(
    .W       (W),
    .OPW     (OPW),
    .AI_BASE (AI_BASE),
    .AI_SIZE (AI_SIZE),
    .AD_BASE (AD_BASE),
    .AD_SIZE (AD_SIZE)
  ) u_decode (
    .clk      (clk),
    .nreset   (nreset),
    .latch_en (latch_en),
    .ibus     (ibus),
    .naindex  (naindex),
    .dec      (dec),
    .operand  (operand)
  );

  assign new_val = dec ? (old_q - W'(STEP)) : (old_q + W'(STEP));

  always_comb begin
    state_d   = state_q;
    old_d     = old_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    overrun_d = overrun_q | (!nwir && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = naindex ? ST_DONE : ST_RD;
      end
      ST_RD: begin
        if (mem_ack) begin
          old_d   = mem_rdata;
          state_d = ST_MOD;
        end
      end
      ST_MOD: begin
        wdata_d = new_val;
        ptr_d   = (PRE != 0) ? new_val : old_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      old_q     <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      old_q     <= old_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      overrun_q <= overrun_d;
    end
  end

  // Bus controls decode straight from the state flop so reset drops them at once.
  assign mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = {{(W-OPW){1'b0}}, operand};
  assign mem_wdata = wdata_q;
  assign ptr       = ptr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pb2_autoindex_unit.sv
// tb/tb_pb2_autoindex_unit.sv - directed self-checking bench: default unit and AD-window/pre-modify unit
module tb_pb2_autoindex_unit;

  logic        clk = 1'b0;
  logic        nreset, nwir, start, mem_ack;
  logic [15:0] ibus, mem_rdata;

  logic        n0, d0, rq0, we0, bz0, dn0, ov0;
  logic [15:0] ad0, wd0, p0;
  logic        n1, d1, rq1, we1, bz1, dn1, ov1;
  logic [15:0] ad1, wd1, p1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pb2_autoindex_unit u0 (
    .clk(clk), .nreset(nreset), .ibus(ibus), .nwir(nwir), .start(start),
    .naindex(n0), .dec(d0), .mem_req(rq0), .mem_we(we0), .mem_addr(ad0),
    .mem_wdata(wd0), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ptr(p0),
    .busy(bz0), .done(dn0), .overrun(ov0)
  );

  pb2_autoindex_unit #(.AD_SIZE('h080), .PRE(1)) u1 (
    .clk(clk), .nreset(nreset), .ibus(ibus), .nwir(nwir), .start(start),
    .naindex(n1), .dec(d1), .mem_req(rq1), .mem_we(we1), .mem_addr(ad1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ptr(p1),
    .busy(bz1), .done(dn1), .overrun(ov1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    ibus = v;
    nwir = 1'b0;
    tick();
    nwir = 1'b1;
  endtask

  // Golden window model: AI window 0x080..0x0FF; AD window 0x100..0x17F when enabled.
  function automatic logic [1:0] golden(input logic [15:0] v, input bit ad_on);
    logic [9:0] op;
    logic       ir, ai, ad;
    op = v[9:0];
    ir = v[11] && v[10];
    ai = (op >= 10'h080) && (op <= 10'h0FF);
    ad = ad_on && (op >= 10'h100) && (op <= 10'h17F);
    return {!(ir && (ai || ad)), ir && !ai && ad};
  endfunction

  initial begin
    nreset = 1'b0; nwir = 1'b1; start = 1'b0; ibus = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_naindex", n0, 1);  chk("rst_dec", d0, 0);   chk("rst_req", rq0, 0);
    chk("rst_we", we0, 0);      chk("rst_addr", ad0, 0); chk("rst_wdata", wd0, 0);
    chk("rst_ptr", p0, 0);      chk("rst_busy", bz0, 0); chk("rst_done", dn0, 0);
    chk("rst_ovr", ov0, 0);
    nreset = 1'b1;
    tick();

    // Window decode
    load(16'h0C85); chk("t1_n0_c85", n0, 0); chk("t1_d0_c85", d0, 0); chk("t1_n1_c85", n1, 0);
    load(16'h0885); chk("t1_n0_r0", n0, 1);
    load(16'h0C7F); chk("t1_n0_07f", n0, 1); chk("t1_n1_07f", n1, 1);
    load(16'h0D00); chk("t1_n0_100", n0, 1); chk("t1_n1_100", n1, 0); chk("t1_d1_100", d1, 1);

    // Zero-wait increment
    load(16'h0C85);
    mem_ack = 1'b1; mem_rdata = 16'h1234; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_rd_req", rq0, 1); chk("t2_rd_we", we0, 0); chk("t2_rd_addr", ad0, 16'h0085);
    tick(); chk("t2_mod_req", rq0, 0);
    tick(); chk("t2_wr_req", rq0, 1); chk("t2_wr_we", we0, 1);
    chk("t2_wr_addr", ad0, 16'h0085); chk("t2_wd0", wd0, 16'h1235); chk("t2_wd1", wd1, 16'h1235);
    chk("t2_wr_done", dn0, 0);
    tick(); chk("t2_done0", dn0, 1); chk("t2_done1", dn1, 1);
    chk("t2_ptr0", p0, 16'h1234); chk("t2_ptr1", p1, 16'h1235);
    tick(); chk("t2_done_off", dn0, 0); chk("t2_busy_off", bz0, 0);

    // Increment wrap
    mem_rdata = 16'hFFFF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t3_wrap_wd0", wd0, 16'h0000); chk("t3_wrap_wd1", wd1, 16'h0000);
    tick(); chk("t3_wrap_ptr0", p0, 16'hFFFF); chk("t3_wrap_ptr1", p1, 16'h0000);
    tick();

    // Decrement wrap in AD window (u1); u0 sees no match and completes directly
    load(16'h0D10);
    chk("t3_n1_d10", n1, 0); chk("t3_d1_d10", d1, 1); chk("t3_n0_d10", n0, 1);
    mem_rdata = 16'h0000; start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_u0_done", dn0, 1); chk("t3_u0_noreq", rq0, 0); chk("t3_u1_rd", rq1, 1);
    tick(); tick();
    chk("t3_dec_wd1", wd1, 16'hFFFF); chk("t3_dec_addr1", ad1, 16'h0110);
    tick(); chk("t3_dec_done1", dn1, 1); chk("t3_dec_ptr1", p1, 16'hFFFF); chk("t3_u0_ptr_keep", p0, 16'hFFFF);
    tick();

    // Wait states in RD and overrun
    load(16'h0C85);
    mem_ack = 1'b0; mem_rdata = 16'h00AA; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("t4_hold_req", rq0, 1); chk("t4_hold_we", we0, 0); chk("t4_hold_addr", ad0, 16'h0085);
      if (i == 2) begin ibus = 16'h0885; nwir = 1'b0; end
      tick();
      nwir = 1'b1;
    end
    chk("t4_ovr0", ov0, 1); chk("t4_ovr1", ov1, 1); chk("t4_latch_keep", n0, 0); chk("t4_addr_keep", ad0, 16'h0085);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("t4_mod_req", rq0, 0);
    tick(); chk("t4_wr_we", we0, 1); chk("t4_wr_wd", wd0, 16'h00AB);
    tick(); chk("t4_wr_hold_req", rq0, 1); chk("t4_wr_hold_wd", wd0, 16'h00AB);

    // Reset mid-write
    nreset = 1'b0;
    #1;
    chk("t5_req0", rq0, 0); chk("t5_req1", rq1, 0); chk("t5_we", we0, 0); chk("t5_naindex", n0, 1);
    chk("t5_addr", ad0, 0); chk("t5_wdata", wd0, 0); chk("t5_ptr", p0, 0); chk("t5_busy", bz0, 0);
    chk("t5_ovr", ov0, 0); chk("t5_dec1", d1, 0);
    tick(); nreset = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_direct_done", dn0, 1); chk("t5_direct_noreq", rq0, 0); chk("t5_direct_ptr", p0, 0);
    tick(); chk("t5_idle", bz0, 0);

    // Exhaustive decode sweep
    nwir = 1'b0;
    for (int v = 0; v < 65536; v++) begin
      logic [1:0] g0, g1;
      ibus = 16'(v);
      g0 = golden(16'(v), 1'b0);
      g1 = golden(16'(v), 1'b1);
      tick();
      chk("sweep_n0", n0, g0[1]); chk("sweep_d0", d0, g0[0]);
      chk("sweep_n1", n1, g1[1]); chk("sweep_d1", d1, g1[0]);
    end
    nwir = 1'b1;
    chk("t6_ovr_clear", ov0, 0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t6_direct_done", dn0, 1); chk("t6_direct_noreq", rq0, 0); chk("t6_direct_noreq1", rq1, 0);
    tick(); chk("t6_idle", bz0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
